alu_op_sequencer: RTL and testbench

Multi-cycle Moore controller that drives the 16-bit register-file / A-B-C / ALU datapath. It accepts one decoded command at a time over a valid/ready handshake. For each command it sequences register reads into A and B, the ALU operation, status (Z) capture and register-file writeback. It sits between the instruction decoder and the datapath, and it is the only block that drives datapath load/select/write strobes.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq_perf_cnt.sv | 22 ++
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: command and state
// encodings, ALU operation codes and default datapath widths.
package alu_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RN_W   = 3;

    typedef enum logic [2:0] {
        MOV_IMM = 3'd0,
        MOV_REG = 3'd1,
        ADD     = 3'd2,
        CMP     = 3'd3,
        AND     = 3'd4,
        MVN     = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        GET_A,
        GET_B,
        OPERATE,
        WRITE_REG,
        WRITE_IMM,
        DONE
    } state_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Opcodes 6 and 7 have no encoding and complete as errors.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command channel between the instruction decoder (master) and the
// sequencer (slave): valid/ready accept plus done/error completion pulses.
interface alu_seq_if #(
    parameter int DATA_W = alu_seq_pkg::DEF_DATA_W,
    parameter int RN_W   = alu_seq_pkg::DEF_RN_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [RN_W-1:0]   cmd_rd;
    logic [RN_W-1:0]   cmd_rn;
    logic [RN_W-1:0]   cmd_rm;
    logic [DATA_W-1:0] cmd_imm;
    logic              done;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        input  cmd_ready, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        output cmd_ready, done, cmd_err
    );
endinterface

// File: rtl/alu_seq_perf_cnt.sv
// Saturating completed-command counter; only instantiated when the
// sequencer is built with ALU_SEQ_PERF_CNT_EN.
module alu_seq_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/alu_op_sequencer.sv
// Moore controller sequencing register reads, ALU op, Z capture and writeback.
// Optional build macro ALU_SEQ_PERF_CNT_EN enables the perf_cmds counter.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RN_W   = DEF_RN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_seq_if.slave          cmd_if,
    output logic [RN_W-1:0]   readnum,
    output logic [RN_W-1:0]   writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              vsel,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] imm_out,
    output logic [15:0]       perf_cmds
);
    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_op;
    logic [RN_W-1:0]   r_rd;
    logic [RN_W-1:0]   r_rn;
    logic [RN_W-1:0]   r_rm;
    logic [DATA_W-1:0] r_imm;
    logic              w_accept;
    logic              w_done;

    assign w_accept = (r_state == IDLE) && cmd_if.cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command fields are captured only on accept so later input changes cannot reach the strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_rn  <= '0;
            r_rm  <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= cmd_if.cmd_op;
            r_rd  <= cmd_if.cmd_rd;
            r_rn  <= cmd_if.cmd_rn;
            r_rm  <= cmd_if.cmd_rm;
            r_imm <= cmd_if.cmd_imm;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_if.cmd_valid) w_state_next = DECODE;
            end
            DECODE: begin
                case (r_op)
                    MOV_IMM:       w_state_next = WRITE_IMM;
                    ADD, AND, CMP: w_state_next = GET_A;
                    MOV_REG, MVN:  w_state_next = GET_B;
                    default:       w_state_next = DONE;
                endcase
            end
            GET_A:     w_state_next = GET_B;
            GET_B:     w_state_next = OPERATE;
            OPERATE:   w_state_next = (r_op == CMP) ? DONE : WRITE_REG;
            WRITE_REG: w_state_next = DONE;
            WRITE_IMM: w_state_next = DONE;
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        alu_op   = ALU_ADD;
        w_done   = 1'b0;
        case (r_state)
            GET_A: begin
                readnum = r_rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = r_rm;
                loadb   = 1'b1;
            end
            OPERATE: begin
                case (r_op)
                    MOV_REG: begin
                        loadc  = 1'b1;
                        asel   = 1'b1;
                        alu_op = ALU_ADD;
                    end
                    CMP: begin
                        loads  = 1'b1;
                        alu_op = ALU_SUB;
                    end
                    AND: begin
                        loadc  = 1'b1;
                        alu_op = ALU_AND;
                    end
                    MVN: begin
                        loadc  = 1'b1;
                        alu_op = ALU_NOTB;
                    end
                    default: begin
                        loadc  = 1'b1;
                        alu_op = ALU_ADD;
                    end
                endcase
            end
            WRITE_REG: begin
                writenum = r_rd;
                write    = 1'b1;
            end
            WRITE_IMM: begin
                writenum = r_rd;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cmd_if.cmd_ready = (r_state == IDLE);
    assign cmd_if.done      = w_done;
    assign cmd_if.cmd_err   = w_done && !is_legal_op(r_op);
    assign imm_out          = r_imm;

`ifdef ALU_SEQ_PERF_CNT_EN
    alu_seq_perf_cnt #(
        .CNT_W (16)
    ) u_perf_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_done),
        .o_count (perf_cmds)
    );
`else
    assign perf_cmds = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: scripted and random commands drive a behavioural
// datapath; results are compared against a per-command reference model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, vsel;
    logic [1:0]  alu_op;
    logic [15:0] imm_out, perf_cmds;

    alu_seq_if cmd_if ();

    alu_op_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_if    (cmd_if),
        .readnum   (readnum),
        .writenum  (writenum),
        .write     (write),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .vsel      (vsel),
        .alu_op    (alu_op),
        .imm_out   (imm_out),
        .perf_cmds (perf_cmds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural register file / A-B-C / ALU datapath obeying the strobes.
    logic [15:0] dp_r [8];
    logic [15:0] dp_a, dp_b, dp_c;
    logic        dp_z;

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (write) dp_r[writenum] <= vsel ? imm_out : dp_c;
        if (loada) dp_a <= dp_r[readnum];
        if (loadb) dp_b <= dp_r[readnum];
        if (loadc) dp_c <= alu_f(alu_op, asel ? 16'h0 : dp_a, dp_b);
        if (loads) dp_z <= (alu_f(alu_op, asel ? 16'h0 : dp_a, dp_b) == 16'h0);
    end

    // Reference: architectural effect and cycle budget of each command.
    logic [15:0] ref_r [8];
    logic        ref_z;
    int          exp_perf;

    function automatic int exp_lat(input int op);
        case (op)
            0:       return 3;
            2, 4:    return 6;
            1, 3, 5: return 5;
            default: return 2;
        endcase
    endfunction

    task automatic ref_apply(input int op, input int rd, input int rn, input int rm, input logic [15:0] imm);
        case (op)
            0: ref_r[rd] = imm;
            1: ref_r[rd] = ref_r[rm];
            2: ref_r[rd] = ref_r[rn] + ref_r[rm];
            3: ref_z     = (ref_r[rn] == ref_r[rm]);
            4: ref_r[rd] = ref_r[rn] & ref_r[rm];
            5: ref_r[rd] = ~ref_r[rm];
            default: ;
        endcase
`ifdef ALU_SEQ_PERF_CNT_EN
        if (exp_perf < 65535) exp_perf++;
`endif
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_cmd(input int op, input int rd, input int rn, input int rm, input logic [15:0] imm);
        int  waits = 0;
        bit  got = 0;
        int  lat = -1, wr_cyc = -1, err = 0;
        int  n_wr = 0, n_la = 0, n_lb = 0, n_ls = 0, n_as = 0, n_busy = 0;
        int  lat_e, wr_e;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'(op);
        cmd_if.cmd_rd    = 3'(rd);
        cmd_if.cmd_rn    = 3'(rn);
        cmd_if.cmd_rm    = 3'(rm);
        cmd_if.cmd_imm   = imm;
        for (int w = 0; w < 10; w++) begin
            if (cmd_if.cmd_ready === 1'b1) begin
                got = 1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        check_eq("accept", 32'(got), 1);
        check_eq("accept_wait", waits, 0);
        if (!got) begin
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_rd    = 3'($urandom);
        cmd_if.cmd_rn    = 3'($urandom);
        cmd_if.cmd_rm    = 3'($urandom);
        cmd_if.cmd_imm   = 16'($urandom);
        for (int k = 1; k <= 20; k++) begin
            n_wr   += int'(write);
            n_la   += int'(loada);
            n_lb   += int'(loadb);
            n_ls   += int'(loads);
            n_as   += int'(asel);
            n_busy += int'(cmd_if.cmd_ready);
            if (write && wr_cyc < 0) wr_cyc = k;
            if (cmd_if.done === 1'b1) begin
                lat = k;
                err = int'(cmd_if.cmd_err);
                break;
            end
            @(negedge clk);
        end
        lat_e = exp_lat(op);
        wr_e  = (op <= 5 && op != 3) ? lat_e - 1 : -1;
        check_eq("latency", lat, lat_e);
        check_eq("cmd_err", err, (op > 5) ? 1 : 0);
        check_eq("write_cnt", n_wr, (wr_e > 0) ? 1 : 0);
        check_eq("write_cycle", wr_cyc, wr_e);
        check_eq("loada_cnt", n_la, (op == 2 || op == 3 || op == 4) ? 1 : 0);
        check_eq("loadb_cnt", n_lb, (op >= 1 && op <= 5) ? 1 : 0);
        check_eq("loads_cnt", n_ls, (op == 3) ? 1 : 0);
        check_eq("asel_cnt", n_as, (op == 1) ? 1 : 0);
        check_eq("ready_busy", n_busy, 0);
        ref_apply(op, rd, rn, rm, imm);
        @(negedge clk);
        check_eq("ready_after", 32'(cmd_if.cmd_ready), 1);
        check_eq("reg_rd", dp_r[rd], ref_r[rd]);
        if (op == 3) check_eq("z_flag", 32'(dp_z), 32'(ref_z));
        check_eq("perf_cmds", perf_cmds, exp_perf);
        $display("cmd op=%0d rd=%0d rn=%0d rm=%0d imm=%h lat=%0d err=%0d r[rd]=%h",
                 op, rd, rn, rm, imm, lat, err, dp_r[rd]);
    endtask

    task automatic reset_during_add();
        int n_wr = 0, n_dn = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd2;
        cmd_if.cmd_rd    = 3'd6;
        cmd_if.cmd_rn    = 3'd0;
        cmd_if.cmd_rm    = 3'd1;
        cmd_if.cmd_imm   = 16'hABCD;
        check_eq("rst_accept", 32'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_getb_loadb", 32'(loadb), 1);
        check_eq("rst_getb_readnum", 32'(readnum), 1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_loadb", 32'(loadb), 0);
        check_eq("rst_readnum", 32'(readnum), 0);
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 1);
        check_eq("rst_imm_out", imm_out, 0);
        check_eq("rst_perf", perf_cmds, 0);
        exp_perf = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) reset_n = 1'b1;
            n_wr += int'(write);
            n_dn += int'(cmd_if.done);
        end
        check_eq("rst_no_write", n_wr, 0);
        check_eq("rst_no_done", n_dn, 0);
        check_eq("rst_r6_kept", dp_r[6], 16'h1234);
        check_eq("rst_ready_after", 32'(cmd_if.cmd_ready), 1);
        $display("cmd reset during ADD GET_B: writes=%0d dones=%0d r6=%h", n_wr, n_dn, dp_r[6]);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            dp_r[i]  = 16'h0;
            ref_r[i] = 16'h0;
        end
        dp_a = '0; dp_b = '0; dp_c = '0; dp_z = 1'b0;
        ref_z = 1'b0;
        exp_perf = 0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_rd    = '0;
        cmd_if.cmd_rn    = '0;
        cmd_if.cmd_rm    = '0;
        cmd_if.cmd_imm   = '0;

        repeat (2) @(negedge clk);
        check_eq("reset_ready", 32'(cmd_if.cmd_ready), 1);
        check_eq("reset_done", 32'(cmd_if.done), 0);
        check_eq("reset_write", 32'(write), 0);
        check_eq("reset_alu_op", 32'(alu_op), 0);
        check_eq("reset_imm_out", imm_out, 0);
        check_eq("reset_perf", perf_cmds, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 3, 0, 0, 16'h0F80);
        check_eq("mov_imm_r3", dp_r[3], 16'h0F80);
        run_cmd(0, 0, 0, 0, 16'h0F80);
        run_cmd(0, 1, 0, 0, 16'h0070);
        run_cmd(2, 2, 0, 1, 16'h0000);
        check_eq("add_r2", dp_r[2], 16'h0FF0);
        run_cmd(3, 0, 0, 0, 16'h0000);
        check_eq("cmp_z", 32'(dp_z), 1);
        run_cmd(0, 1, 0, 0, 16'h0F90);
        run_cmd(1, 4, 0, 1, 16'h0000);
        check_eq("mov_reg_r4", dp_r[4], 16'h0F90);
        run_cmd(5, 5, 0, 1, 16'h0000);
        check_eq("mvn_r5", dp_r[5], 16'hF06F);
        run_cmd(7, 0, 0, 0, 16'h0000);
        run_cmd(2, 7, 3, 5, 16'h0000);
        run_cmd(0, 6, 0, 0, 16'h1234);

        reset_during_add();

        for (int t = 0; t < 40; t++) begin
            int op;
            op = (t % 8 == 0) ? 3 : int'($urandom_range(0, 7));
            run_cmd(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
